pc_fetch_unit: RTL

//  Program-counter register and next-PC selection for the single-cycle RISC core.

---
 rtl/pc_fetch_if.sv | 24 ++
 rtl/pc_fetch_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-side bus between the core datapath and the PC register.
// Handshake: an imem request is outstanding while PCValid=1; it is consumed on a rising
// edge where ImemReady=1 and Stall=0, and only then may PC change.
interface pc_fetch_if;
  logic [31:0] PCPlus4;
  logic [31:0] PCTarget;
  logic [1:0]  PCSrc;
  logic        Stall;
  logic        ImemReady;
  logic [31:0] PC;
  logic        PCValid;
  logic        MisalignedFault;
  logic [31:0] FaultPC;

  modport master (
    output PCPlus4, PCTarget, PCSrc, Stall, ImemReady,
    input  PC, PCValid, MisalignedFault, FaultPC
  );

  modport slave (
    input  PCPlus4, PCTarget, PCSrc, Stall, ImemReady,
    output PC, PCValid, MisalignedFault, FaultPC
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter register with next-PC selection, boot delay, stall hold,
// buffered redirects and misaligned-target trapping.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  pc_fetch_if.slave   bus,
  output logic        o_dbg_state
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_boot_cnt;
  logic [31:0] r_pc;
  logic        r_pc_valid;
  logic        r_fault;
  logic [31:0] r_fault_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_pc;

  logic        w_adv;
  logic [31:0] w_tgt;
  logic [31:0] w_nxt;
  logic        w_misaligned;

  always_comb begin
    w_adv = ~bus.Stall & bus.ImemReady;
    w_tgt = 32'h0;
    case (bus.PCSrc)
      2'b01:   w_tgt = bus.PCTarget;
      2'b10:   w_tgt = {bus.PCTarget[31:1], 1'b0};
      2'b11:   w_tgt = TRAP_VECTOR;
      default: w_tgt = 32'h0;
    endcase
    // A redirect presented on the advance cycle beats an older buffered one.
    if (bus.PCSrc != 2'b00)  w_nxt = w_tgt;
    else if (r_pend_valid)   w_nxt = r_pend_pc;
    else                     w_nxt = bus.PCPlus4;
    w_misaligned = (w_nxt != TRAP_VECTOR) && (w_nxt[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_BOOT;
      r_boot_cnt   <= 4'd0;
      r_pc         <= RESET_VECTOR;
      r_pc_valid   <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_pc   <= 32'h0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'h0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          if (r_boot_cnt == 4'(BOOT_CYCLES - 1)) begin
            r_state    <= ST_RUN;
            r_pc_valid <= 1'b1;
            r_boot_cnt <= 4'd0;
          end else begin
            r_boot_cnt <= r_boot_cnt + 4'd1;
          end
        end
        ST_RUN: begin
          if (w_adv) begin
            r_pend_valid <= 1'b0;
            if (w_misaligned) begin
              r_pc       <= TRAP_VECTOR;
              r_fault    <= 1'b1;
              r_fault_pc <= w_nxt;
            end else begin
              r_pc <= w_nxt;
            end
          end else if (bus.PCSrc != 2'b00) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= w_tgt;
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign bus.PC              = r_pc;
  assign bus.PCValid         = r_pc_valid;
  assign bus.MisalignedFault = r_fault;
  assign bus.FaultPC         = r_fault_pc;
  assign o_dbg_state         = r_state;

endmodule
